sram_bus_arbiter: RTL and testbench
===================================

Name: sram_bus_arbiter

Overview:
- Shares the single 32-bit SRAM interface (base/ext banks) between the CPU instruction-fetch port and data-memory port.
- Sequences multi-cycle read and write strobes with explicit setup and hold.
- Returns read data and one-cycle acks; generates per-port stall signals so the pipeline can run at full clock with slow SRAM.
- Sits between the CPU core and the top-level SRAM pin drivers; the top level muxes base/ext pins using sram_bank_o.

Parameters:
- WAIT_CYCLES, 2, number of cycles oe_n is held low before read data is sampled (min 1).
- WE_CYCLES, 2, number of cycles we_n is held low on writes (min 1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- if_req_i  in  1  fetch request; held until if_ack_o
- if_addr_i  in  32  fetch byte address
- if_data_o  out  32  fetch read data, valid while if_ack_o=1
- if_ack_o  out  1  one-cycle completion pulse for the fetch port
- if_stall_o  out  1  if_req_i & ~if_ack_o
- mem_req_i  in  1  data request; held until mem_ack_o
- mem_we_i  in  1  1=write, 0=read
- mem_addr_i  in  32  data byte address
- mem_sel_i  in  4  byte enables, active-high
- mem_data_i  in  32  write data
- mem_data_o  out  32  read data, valid while mem_ack_o=1
- mem_ack_o  out  1  one-cycle completion pulse for the data port
- mem_stall_o  out  1  mem_req_i & ~mem_ack_o
- sram_addr_o  out  20  word address = latched addr[21:2]
- sram_bank_o  out  1  latched addr[22]; 0=base, 1=ext
- sram_be_n_o  out  4  byte enables, active-low
- sram_ce_n_o  out  1  chip enable, active-low
- sram_oe_n_o  out  1  output enable, active-low
- sram_we_n_o  out  1  write enable, active-low
- sram_dout_o  out  32  write data to the pad tristate
- sram_dout_en_o  out  1  1 = top level drives the data bus
- sram_din_i  in  32  data bus input

Behaviour:
- All SRAM and ack outputs are registered.
- Reset values:
  - ce_n/oe_n/we_n = 1, be_n = 4'hF, addr = 0, bank = 0, dout = 0, dout_en = 0.
  - Both acks = 0; both data outputs = 0.
  - state = IDLE, last_owner = IF.
- Reset is asynchronous: asserting it mid-transaction immediately returns all outputs to their reset values. No ack is issued for the aborted access.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE. A counter cnt is cleared on every state entry.
- IDLE arbitration, evaluated each edge:
  - Only one port requesting: that port is granted.
  - Both requesting: grant the port that is not last_owner (round-robin). Data wins the first contention after reset.
  - On grant: latch owner, addr, we, sel, and wdata; update last_owner.
- IDLE → RD (read) or WR_SETUP (write).
- Byte enables:
  - Fetch: be_n = 4'h0.
  - Data: be_n = ~sel.
  - Data write with sel = 0: sequence runs normally, but we_n stays 1 throughout (no-op write that still completes with an ack).
- RD:
  - ce_n = 0, oe_n = 0 for WAIT_CYCLES cycles.
  - On the last cycle, sram_din_i is captured into the owner's data register.
  - Then go to DONE.
- WR_SETUP: 1 cycle; ce_n = 0, dout_en = 1, we_n = 1.
- WR_PULSE: WE_CYCLES cycles with we_n = 0.
- WR_HOLD: 1 cycle; we_n = 1, dout_en = 1, ce_n = 0.
- DONE:
  - ce_n/oe_n/we_n = 1, dout_en = 0.
  - The owner's ack = 1 for exactly one cycle; the data output is held valid through and after the ack until the next capture.
  - Always returns to IDLE.
- Latency, counted in cycles after the grant edge: read ack high at WAIT_CYCLES+1 (3 by default); write ack high at WE_CYCLES+3 (5 by default).
- Back-to-back: requests are not sampled in DONE. The earliest next grant is the edge ending the IDLE cycle after DONE.
  - Requesters must drop req at the edge where they observe ack.
  - A req still high in IDLE is treated as a new request.
- req dropped before ack: the latched transaction still completes and acks; the ack is ignored by the requester.
- dout_en = 1 only in WR_SETUP, WR_PULSE and WR_HOLD, so the bus is never driven while oe_n = 0.
- Address, bank and be_n remain stable from the first strobe cycle through DONE.

Test Plan:
- Reset, then fetch read addr 0x0000_0010, sram_din = 0x1234_5678 → sram_addr = 0x4, bank = 0, be_n = 0, oe_n low for 2 cycles; if_ack pulses at cycle 3 with if_data = 0x1234_5678; if_stall high for cycles 0–2.
- Data write addr 0x0040_0008, sel = 4'b0011, data = 0xAABB_CCDD → bank = 1, sram_addr = 0x2, be_n = 4'b1100; we_n low exactly in cycles 2–3 with dout_en high in cycles 1–4; mem_ack at cycle 5.
- if_req and mem_req both held high continuously → grants alternate mem, if, mem, if; no port is starved; each ack is a single-cycle pulse.
- Write with sel = 0 → we_n never falls; mem_ack still pulses after 5 cycles.
- Assert rst during WR_PULSE → we_n, ce_n and dout_en go to 1/1/0 without waiting for a clock edge; no ack; after release, a new read completes normally.
- WAIT_CYCLES = 4, WE_CYCLES = 1 → read ack at cycle 5; write we_n low for exactly 1 cycle with ack at cycle 4.

Source files
------------

// File: rtl/sram_bus_arbiter_if.sv
// CPU-side fetch/data request ports plus the SRAM pin-side bus of the arbiter.
// The arbiter uses the slave modport; the CPU core and pad drivers sit on the master side.
interface sram_bus_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ack_o;
  logic        if_stall_o;

  logic        mem_req_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_ack_o;
  logic        mem_stall_o;

  logic [19:0] sram_addr_o;
  logic        sram_bank_o;
  logic [3:0]  sram_be_n_o;
  logic        sram_ce_n_o;
  logic        sram_oe_n_o;
  logic        sram_we_n_o;
  logic [31:0] sram_dout_o;
  logic        sram_dout_en_o;
  logic [31:0] sram_din_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_data_o, if_ack_o, if_stall_o,
    input  mem_req_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    output mem_data_o, mem_ack_o, mem_stall_o,
    output sram_addr_o, sram_bank_o, sram_be_n_o, sram_ce_n_o, sram_oe_n_o,
    output sram_we_n_o, sram_dout_o, sram_dout_en_o,
    input  sram_din_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_data_o, if_ack_o, if_stall_o,
    output mem_req_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    input  mem_data_o, mem_ack_o, mem_stall_o,
    input  sram_addr_o, sram_bank_o, sram_be_n_o, sram_ce_n_o, sram_oe_n_o,
    input  sram_we_n_o, sram_dout_o, sram_dout_en_o,
    output sram_din_i
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Round-robin arbiter sharing one async SRAM between fetch and data ports; read ack WAIT_CYCLES+1, write ack WE_CYCLES+3 cycles after grant.
// Requesters stall until their one-cycle ack; new requests are only sampled in IDLE.
module sram_bus_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int WE_CYCLES   = 2
) (
  input logic               clk,
  input logic               rst,
  sram_bus_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_DONE
  } state_t;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  localparam int               CNT_W   = 8;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WE_LAST = CNT_W'(WE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  logic        owner_q;
  logic        last_owner_q;
  logic        we_q;
  logic [20:0] addr_q;
  logic [3:0]  sel_q;
  logic [31:0] wdata_q;

  logic grant_mem, grant_if;

  logic ce_n_d, oe_n_d, we_n_d, dout_en_d;
  logic if_ack_d, mem_ack_d, cap_if, cap_mem;

  logic        ce_n_q, oe_n_q, we_n_q, dout_en_q;
  logic [19:0] sram_addr_q;
  logic        bank_q;
  logic [3:0]  be_n_q;
  logic [31:0] dout_q;
  logic        if_ack_q, mem_ack_q;
  logic [31:0] if_data_q, mem_data_q;

  // Word address and bank only use addr[22:2].
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr_i[31:23], bus.if_addr_i[1:0],
                              bus.mem_addr_i[31:23], bus.mem_addr_i[1:0]};

  // On contention the port that did not own the bus last time wins.
  always_comb begin
    grant_mem = bus.mem_req_i & (~bus.if_req_i | (last_owner_q == OWN_IF));
    grant_if  = bus.if_req_i & ~grant_mem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_IF;
      we_q         <= 1'b0;
      addr_q       <= '0;
      sel_q        <= '0;
      wdata_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (state_q != S_IDLE) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == S_IDLE && (grant_mem || grant_if)) begin
        owner_q      <= grant_mem;
        last_owner_q <= grant_mem;
        we_q         <= grant_mem & bus.mem_we_i;
        addr_q       <= grant_mem ? bus.mem_addr_i[22:2] : bus.if_addr_i[22:2];
        sel_q        <= grant_mem ? bus.mem_sel_i : 4'hF;
        wdata_q      <= bus.mem_data_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_mem && bus.mem_we_i) begin
          state_d = S_WR_SETUP;
        end else if (grant_mem || grant_if) begin
          state_d = S_RD;
        end
      end
      S_RD:       if (cnt_q == RD_LAST) state_d = S_DONE;
      S_WR_SETUP: state_d = S_WR_PULSE;
      S_WR_PULSE: if (cnt_q == WE_LAST) state_d = S_WR_HOLD;
      S_WR_HOLD:  state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the current state and registered, so pins lag the state by one cycle.
  always_comb begin
    ce_n_d    = 1'b1;
    oe_n_d    = 1'b1;
    we_n_d    = 1'b1;
    dout_en_d = 1'b0;
    if_ack_d  = 1'b0;
    mem_ack_d = 1'b0;
    cap_if    = 1'b0;
    cap_mem   = 1'b0;
    case (state_q)
      S_RD: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      S_WR_SETUP, S_WR_HOLD: begin
        ce_n_d    = 1'b0;
        dout_en_d = 1'b1;
      end
      S_WR_PULSE: begin
        ce_n_d    = 1'b0;
        dout_en_d = 1'b1;
        we_n_d    = ~|sel_q;
      end
      S_DONE: begin
        if_ack_d  = (owner_q == OWN_IF);
        mem_ack_d = (owner_q == OWN_MEM);
        cap_if    = (owner_q == OWN_IF) & ~we_q;
        cap_mem   = (owner_q == OWN_MEM) & ~we_q;
      end
      default: ;
    endcase
  end

  // Read data is sampled at the edge that ends the last oe_n-low pin cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dout_en_q   <= 1'b0;
      sram_addr_q <= '0;
      bank_q      <= 1'b0;
      be_n_q      <= 4'hF;
      dout_q      <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_data_q   <= '0;
      mem_data_q  <= '0;
    end else begin
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      dout_en_q   <= dout_en_d;
      sram_addr_q <= addr_q[19:0];
      bank_q      <= addr_q[20];
      be_n_q      <= ~sel_q;
      dout_q      <= wdata_q;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if (cap_if) begin
        if_data_q <= bus.sram_din_i;
      end
      if (cap_mem) begin
        mem_data_q <= bus.sram_din_i;
      end
    end
  end

  assign bus.sram_ce_n_o    = ce_n_q;
  assign bus.sram_oe_n_o    = oe_n_q;
  assign bus.sram_we_n_o    = we_n_q;
  assign bus.sram_dout_en_o = dout_en_q;
  assign bus.sram_addr_o    = sram_addr_q;
  assign bus.sram_bank_o    = bank_q;
  assign bus.sram_be_n_o    = be_n_q;
  assign bus.sram_dout_o    = dout_q;
  assign bus.if_ack_o       = if_ack_q;
  assign bus.mem_ack_o      = mem_ack_q;
  assign bus.if_data_o      = if_data_q;
  assign bus.mem_data_o     = mem_data_q;
  assign bus.if_stall_o     = bus.if_req_i & ~if_ack_q;
  assign bus.mem_stall_o    = bus.mem_req_i & ~mem_ack_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: default-parameter instance plus a WAIT_CYCLES=4/WE_CYCLES=1 instance.
// Per-cycle strobe masks: bit k is cycle k after the grant edge.
module tb_sram_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sram_bus_arbiter_if b ();
  sram_bus_arbiter_if b2 ();

  sram_bus_arbiter u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  sram_bus_arbiter #(
    .WAIT_CYCLES (4),
    .WE_CYCLES   (1)
  ) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  // Per-transaction observations filled by run_txn.
  logic [7:0]  m_ce, m_oe, m_we, m_den, m_ifack, m_memack, m_stall;
  logic [19:0] s_addr;
  logic        s_bank;
  logic [3:0]  s_be;
  logic [31:0] s_dout, r_data, r_hold;

  task automatic drive_idle();
    b.if_req_i   = 1'b0; b.if_addr_i  = '0;
    b.mem_req_i  = 1'b0; b.mem_we_i   = 1'b0; b.mem_addr_i = '0;
    b.mem_sel_i  = '0;   b.mem_data_i = '0;   b.sram_din_i = '0;
    b2.if_req_i  = 1'b0; b2.if_addr_i = '0;
    b2.mem_req_i = 1'b0; b2.mem_we_i  = 1'b0; b2.mem_addr_i = '0;
    b2.mem_sel_i = '0;   b2.mem_data_i = '0;  b2.sram_din_i = '0;
  endtask

  // Issues one request at a negedge so the next posedge is the grant edge, then records 8 cycles.
  task automatic run_txn(input bit inst2, input bit is_mem, input bit we, input logic [31:0] addr,
                         input logic [3:0] sel, input logic [31:0] wdata, input logic [31:0] din);
    logic ack, ifa, mema, st;
    logic [31:0] dat;
    @(negedge clk);
    if (inst2) begin
      b2.sram_din_i = din;
      if (is_mem) begin
        b2.mem_we_i = we; b2.mem_addr_i = addr; b2.mem_sel_i = sel; b2.mem_data_i = wdata;
        b2.mem_req_i = 1'b1;
      end else begin
        b2.if_addr_i = addr; b2.if_req_i = 1'b1;
      end
    end else begin
      b.sram_din_i = din;
      if (is_mem) begin
        b.mem_we_i = we; b.mem_addr_i = addr; b.mem_sel_i = sel; b.mem_data_i = wdata;
        b.mem_req_i = 1'b1;
      end else begin
        b.if_addr_i = addr; b.if_req_i = 1'b1;
      end
    end
    m_ce = '0; m_oe = '0; m_we = '0; m_den = '0; m_ifack = '0; m_memack = '0; m_stall = '0;
    r_data = 32'hDEAD_DEAD;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      m_ce[k]  = inst2 ? ~b2.sram_ce_n_o : ~b.sram_ce_n_o;
      m_oe[k]  = inst2 ? ~b2.sram_oe_n_o : ~b.sram_oe_n_o;
      m_we[k]  = inst2 ? ~b2.sram_we_n_o : ~b.sram_we_n_o;
      m_den[k] = inst2 ? b2.sram_dout_en_o : b.sram_dout_en_o;
      ifa      = inst2 ? b2.if_ack_o : b.if_ack_o;
      mema     = inst2 ? b2.mem_ack_o : b.mem_ack_o;
      m_ifack[k]  = ifa;
      m_memack[k] = mema;
      if (is_mem) st = inst2 ? b2.mem_stall_o : b.mem_stall_o;
      else        st = inst2 ? b2.if_stall_o : b.if_stall_o;
      m_stall[k] = st;
      if (is_mem) dat = inst2 ? b2.mem_data_o : b.mem_data_o;
      else        dat = inst2 ? b2.if_data_o : b.if_data_o;
      if (k == 2) begin
        s_addr = inst2 ? b2.sram_addr_o : b.sram_addr_o;
        s_bank = inst2 ? b2.sram_bank_o : b.sram_bank_o;
        s_be   = inst2 ? b2.sram_be_n_o : b.sram_be_n_o;
        s_dout = inst2 ? b2.sram_dout_o : b.sram_dout_o;
      end
      ack = is_mem ? mema : ifa;
      if (ack) begin
        r_data = dat;
        if (inst2) begin b2.if_req_i = 1'b0; b2.mem_req_i = 1'b0; end
        else begin b.if_req_i = 1'b0; b.mem_req_i = 1'b0; end
      end
    end
    r_hold = dat;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({b.sram_ce_n_o, b.sram_oe_n_o, b.sram_we_n_o} !== 3'b111)
      begin errors++; $display("FAIL reset_strobes: got %b want 111", {b.sram_ce_n_o, b.sram_oe_n_o, b.sram_we_n_o}); end
    checks++; if (b.sram_be_n_o !== 4'hF)
      begin errors++; $display("FAIL reset_be_n: got %h want f", b.sram_be_n_o); end
    checks++; if ({b.sram_bank_o, b.sram_addr_o, b.sram_dout_o, b.sram_dout_en_o} !== 54'd0)
      begin errors++; $display("FAIL reset_addr_dout: got bank=%b addr=%h dout=%h en=%b want 0", b.sram_bank_o, b.sram_addr_o, b.sram_dout_o, b.sram_dout_en_o); end
    checks++; if ({b.if_ack_o, b.mem_ack_o, b.if_data_o, b.mem_data_o} !== 66'd0)
      begin errors++; $display("FAIL reset_acks_data: got %b %b %h %h want 0", b.if_ack_o, b.mem_ack_o, b.if_data_o, b.mem_data_o); end
  endtask

  task automatic test_fetch_read();
    run_txn(1'b0, 1'b0, 1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'h1234_5678);
    checks++; if (m_oe !== 8'h06) begin errors++; $display("FAIL fetch_oe_mask: got %b want 00000110", m_oe); end
    checks++; if (m_ce !== 8'h06) begin errors++; $display("FAIL fetch_ce_mask: got %b want 00000110", m_ce); end
    checks++; if (m_ifack !== 8'h08) begin errors++; $display("FAIL fetch_ack_mask: got %b want 00001000", m_ifack); end
    checks++; if (m_stall !== 8'h07) begin errors++; $display("FAIL fetch_stall_mask: got %b want 00000111", m_stall); end
    checks++; if ((m_memack | m_den | m_we) !== 8'h00) begin errors++; $display("FAIL fetch_other: memack=%b den=%b we=%b want 0", m_memack, m_den, m_we); end
    checks++; if ({s_bank, s_addr, s_be} !== {1'b0, 20'h4, 4'h0}) begin errors++; $display("FAIL fetch_addr: got bank=%b addr=%h be_n=%h want 0/00004/0", s_bank, s_addr, s_be); end
    checks++; if (r_data !== 32'h1234_5678) begin errors++; $display("FAIL fetch_data: got %h want 12345678", r_data); end
    checks++; if (r_hold !== 32'h1234_5678) begin errors++; $display("FAIL fetch_data_hold: got %h want 12345678", r_hold); end
  endtask

  task automatic test_data_write();
    run_txn(1'b0, 1'b1, 1'b1, 32'h0040_0008, 4'b0011, 32'hAABB_CCDD, 32'h0);
    checks++; if (m_we !== 8'h0C) begin errors++; $display("FAIL wr_we_mask: got %b want 00001100", m_we); end
    checks++; if (m_den !== 8'h1E) begin errors++; $display("FAIL wr_den_mask: got %b want 00011110", m_den); end
    checks++; if (m_ce !== 8'h1E) begin errors++; $display("FAIL wr_ce_mask: got %b want 00011110", m_ce); end
    checks++; if (m_memack !== 8'h20) begin errors++; $display("FAIL wr_ack_mask: got %b want 00100000", m_memack); end
    checks++; if (m_oe !== 8'h00) begin errors++; $display("FAIL wr_oe_mask: got %b want 00000000", m_oe); end
    checks++; if (m_stall !== 8'h1F) begin errors++; $display("FAIL wr_stall_mask: got %b want 00011111", m_stall); end
    checks++; if ({s_bank, s_addr, s_be} !== {1'b1, 20'h2, 4'b1100}) begin errors++; $display("FAIL wr_addr: got bank=%b addr=%h be_n=%b want 1/00002/1100", s_bank, s_addr, s_be); end
    checks++; if (s_dout !== 32'hAABB_CCDD) begin errors++; $display("FAIL wr_dout: got %h want aabbccdd", s_dout); end
  endtask

  task automatic test_zero_sel_write();
    run_txn(1'b0, 1'b1, 1'b1, 32'h0000_0100, 4'b0000, 32'h5555_AAAA, 32'h0);
    checks++; if (m_we !== 8'h00) begin errors++; $display("FAIL sel0_we_mask: got %b want 00000000", m_we); end
    checks++; if (m_memack !== 8'h20) begin errors++; $display("FAIL sel0_ack_mask: got %b want 00100000", m_memack); end
    checks++; if (m_den !== 8'h1E) begin errors++; $display("FAIL sel0_den_mask: got %b want 00011110", m_den); end
    checks++; if (s_be !== 4'hF) begin errors++; $display("FAIL sel0_be_n: got %h want f", s_be); end
  endtask

  task automatic test_round_robin();
    int n;
    logic [3:0]  ports;
    logic [31:0] cyc;
    logic        both, dbl, prev_if, prev_mem;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    b.sram_din_i = 32'h5A5A_0001;
    b.if_addr_i = 32'h0000_0200; b.mem_addr_i = 32'h0000_0300; b.mem_we_i = 1'b0;
    b.mem_sel_i = 4'hF; b.if_req_i = 1'b1; b.mem_req_i = 1'b1;
    n = 0; ports = '0; cyc = '0; both = 1'b0; dbl = 1'b0; prev_if = 1'b0; prev_mem = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (b.if_ack_o && b.mem_ack_o) both = 1'b1;
      if ((b.if_ack_o && prev_if) || (b.mem_ack_o && prev_mem)) dbl = 1'b1;
      if ((b.if_ack_o || b.mem_ack_o) && n < 4) begin
        ports[n] = b.mem_ack_o;
        cyc[n*8 +: 8] = 8'(k);
        n++;
      end
      prev_if = b.if_ack_o; prev_mem = b.mem_ack_o;
    end
    b.if_req_i = 1'b0; b.mem_req_i = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (n !== 4) begin errors++; $display("FAIL rr_ack_count: got %0d want 4", n); end
    checks++; if (ports !== 4'b0101) begin errors++; $display("FAIL rr_order: got %b want 0101 (mem,if,mem,if)", ports); end
    checks++; if (cyc !== 32'h0F0B_0703) begin errors++; $display("FAIL rr_ack_cycles: got %h want 0f0b0703", cyc); end
    checks++; if ({both, dbl} !== 2'b00) begin errors++; $display("FAIL rr_pulses: both=%b double=%b want 0 0", both, dbl); end
  endtask

  task automatic test_reset_mid_write();
    int acks;
    @(negedge clk);
    b.mem_we_i = 1'b1; b.mem_addr_i = 32'h0000_0400; b.mem_sel_i = 4'hF;
    b.mem_data_i = 32'h1111_1111; b.mem_req_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (b.sram_we_n_o !== 1'b0) begin errors++; $display("FAIL rstw_pulse_active: we_n got %b want 0", b.sram_we_n_o); end
    #1 rst = 1'b1;
    #1;
    checks++; if ({b.sram_we_n_o, b.sram_ce_n_o, b.sram_dout_en_o, b.sram_be_n_o} !== {3'b110, 4'hF})
      begin errors++; $display("FAIL rstw_async: we_n/ce_n/den/be_n got %b%b%b/%h want 110/f", b.sram_we_n_o, b.sram_ce_n_o, b.sram_dout_en_o, b.sram_be_n_o); end
    b.mem_req_i = 1'b0;
    acks = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (b.mem_ack_o || b.if_ack_o) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL rstw_no_ack: got %0d acks want 0", acks); end
    run_txn(1'b0, 1'b0, 1'b0, 32'h0000_0020, 4'h0, 32'h0, 32'hCAFE_F00D);
    checks++; if (m_ifack !== 8'h08) begin errors++; $display("FAIL rstw_read_ack: got %b want 00001000", m_ifack); end
    checks++; if ({s_addr, r_data} !== {20'h8, 32'hCAFE_F00D}) begin errors++; $display("FAIL rstw_read_data: got addr=%h data=%h want 00008/cafef00d", s_addr, r_data); end
  endtask

  task automatic test_params();
    run_txn(1'b1, 1'b0, 1'b0, 32'h0000_0044, 4'h0, 32'h0, 32'h0BAD_BEEF);
    checks++; if (m_oe !== 8'h1E) begin errors++; $display("FAIL p_rd_oe_mask: got %b want 00011110", m_oe); end
    checks++; if (m_ifack !== 8'h20) begin errors++; $display("FAIL p_rd_ack_mask: got %b want 00100000", m_ifack); end
    checks++; if ({s_addr, r_data} !== {20'h11, 32'h0BAD_BEEF}) begin errors++; $display("FAIL p_rd_data: got addr=%h data=%h want 00011/0badbeef", s_addr, r_data); end
    run_txn(1'b1, 1'b1, 1'b1, 32'h0000_0080, 4'hF, 32'h0000_0077, 32'h0);
    checks++; if (m_we !== 8'h04) begin errors++; $display("FAIL p_wr_we_mask: got %b want 00000100", m_we); end
    checks++; if (m_den !== 8'h0E) begin errors++; $display("FAIL p_wr_den_mask: got %b want 00001110", m_den); end
    checks++; if (m_memack !== 8'h10) begin errors++; $display("FAIL p_wr_ack_mask: got %b want 00010000", m_memack); end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_data_write();
    test_zero_sel_write();
    test_round_robin();
    test_reset_mid_write();
    test_params();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
